// File: rtl/memory_controller.sv
// Byte-serial memory controller: arbitrates LSB and fetch requests, splits each access into
// little-endian byte transfers on an 8-bit RAM/IO bus and returns extended load data.
module memory_controller #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        lsb_en,
  input  logic [31:0] lsb_addr,
  input  logic [3:0]  lsb_type,
  input  logic [31:0] lsb_write_data,
  output logic        lsb_rdy,
  output logic [31:0] lsb_read_data,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_rdy,
  output logic [31:0] if_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic        src_lsb_q, src_lsb_d;
  logic        write_q, write_d;
  logic        unsigned_q, unsigned_d;
  logic [2:0]  n_q, n_d;
  logic [2:0]  i_q, i_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] lsb_data_q, lsb_data_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ext;
  logic        is_io, stall, last_wr, last_rd;

  assign is_io   = addr_q[17:16] == IO_BASE[17:16];
  assign stall   = write_q & is_io & io_buffer_full;
  assign last_wr = i_q == n_q - 3'd1;
  // A read needs one extra cycle after the final address to capture its byte.
  assign last_rd = i_q == n_q;

  assign lsb_read_data = lsb_data_q;
  assign if_data       = if_data_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (lsb_en || if_en) state_d = StAccess;
      end
      StAccess: begin
        if (write_q) begin
          if (!stall && last_wr) state_d = StDone;
        end else if (flush) begin
          state_d = StIdle;
        end else if (last_rd) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    src_lsb_d  = src_lsb_q;
    write_d    = write_q;
    unsigned_d = unsigned_q;
    n_d        = n_q;
    i_d        = i_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    lsb_data_d = lsb_data_q;
    if_data_d  = if_data_q;
    ext        = 32'd0;
    unique case (state_q)
      StIdle: begin
        i_d    = 3'd0;
        rbuf_d = 32'd0;
        if (lsb_en) begin
          src_lsb_d  = 1'b1;
          addr_d     = lsb_addr;
          write_d    = lsb_type[3];
          unsigned_d = lsb_type[2];
          wdata_d    = lsb_write_data;
          n_d        = (lsb_type[1:0] == 2'b00) ? 3'd1 : (lsb_type[1:0] == 2'b01) ? 3'd2 : 3'd4;
        end else if (if_en) begin
          src_lsb_d  = 1'b0;
          addr_d     = if_addr;
          write_d    = 1'b0;
          unsigned_d = 1'b1;
          n_d        = 3'd4;
        end
      end
      StAccess: begin
        if (write_q) begin
          if (!stall) i_d = i_q + 3'd1;
        end else begin
          i_d = i_q + 3'd1;
          for (int b = 0; b < 4; b++) begin
            if (i_q == 3'(b + 1)) rbuf_d[8*b +: 8] = mem_din;
          end
          if (n_q == 3'd1)      ext = {{24{~unsigned_q & rbuf_d[7]}}, rbuf_d[7:0]};
          else if (n_q == 3'd2) ext = {{16{~unsigned_q & rbuf_d[15]}}, rbuf_d[15:0]};
          else                  ext = rbuf_d;
          if (last_rd && !flush) begin
            if (src_lsb_q) lsb_data_d = ext;
            else           if_data_d  = ext;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      src_lsb_q  <= 1'b0;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      n_q        <= 3'd0;
      i_q        <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      lsb_data_q <= 32'd0;
      if_data_q  <= 32'd0;
    end else if (rdy_in) begin
      src_lsb_q  <= src_lsb_d;
      write_q    <= write_d;
      unsigned_q <= unsigned_d;
      n_q        <= n_d;
      i_q        <= i_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      lsb_data_q <= lsb_data_d;
      if_data_q  <= if_data_d;
    end
  end

  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    mem_wr   = 1'b0;
    lsb_rdy  = 1'b0;
    if_rdy   = 1'b0;
    unique case (state_q)
      StAccess: begin
        if (write_q || !last_rd) mem_a = addr_q + {29'd0, i_q};
        if (write_q) begin
          mem_dout = 8'(wdata_q >> {i_q, 3'b000});
          mem_wr   = rdy_in & ~stall;
        end
      end
      StDone: begin
        // Stores always report completion; a flush only cancels a read's pulse.
        if (src_lsb_q) lsb_rdy = rdy_in & (write_q | ~flush);
        else           if_rdy  = rdy_in & ~flush;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed and random checks of memory_controller against a byte-array reference model.
module tb_memory_controller;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        lsb_en, lsb_rdy, if_en, if_rdy, mem_wr, io_buffer_full;
  logic [31:0] lsb_addr, lsb_write_data, lsb_read_data, if_addr, if_data, mem_a;
  logic [3:0]  lsb_type;
  logic [7:0]  mem_din, mem_dout;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram   [0:4095];
  logic [7:0]  model [0:4095];
  logic [31:0] io_a;
  logic [7:0]  io_d;
  logic [31:0] q_a  [$];
  logic        q_wr [$];
  logic [7:0]  q_do [$];

  always #5 clk_in = ~clk_in;

  memory_controller dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .flush          (flush),
    .lsb_en         (lsb_en),
    .lsb_addr       (lsb_addr),
    .lsb_type       (lsb_type),
    .lsb_write_data (lsb_write_data),
    .lsb_rdy        (lsb_rdy),
    .lsb_read_data  (lsb_read_data),
    .if_en          (if_en),
    .if_addr        (if_addr),
    .if_rdy         (if_rdy),
    .if_data        (if_data),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  // Bus-side RAM shares the global enable, so read data lines up with a frozen address.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ram[mem_a[11:0]];
    if (mem_wr) begin
      if (mem_a[17:16] == 2'b11) begin
        io_a <= mem_a;
        io_d <= mem_dout;
      end else begin
        ram[mem_a[11:0]] = mem_dout;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [3:0] ty);
    return (ty[1:0] == 2'b00) ? 1 : (ty[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n, input bit sgn);
    longint v;
    v = 0;
    for (int k = 0; k < n; k++)
      v += longint'(model[int'((a + 32'(k)) & 32'hfff)]) << (8 * k);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input int n);
    for (int k = 0; k < n; k++)
      model[int'((a + 32'(k)) & 32'hfff)] = 8'((wd >> (8 * k)) & 32'hff);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] a, input logic [31:0] wd,
                              input int n);
    int w = 0;
    foreach (q_wr[j]) begin
      if (q_wr[j]) begin
        chk({tag, "_addr"}, q_a[j], a + 32'(w));
        chk({tag, "_byte"}, 32'(q_do[j]), (wd >> (8 * w)) & 32'hff);
        w++;
      end
    end
    chk({tag, "_count"}, 32'(w), 32'(n));
  endtask

  // One request; cnt=k samples the k-th cycle after the accepting IDLE cycle.
  task automatic run_req(input bit use_lsb, input logic [31:0] a, input logic [3:0] ty,
                         input logic [31:0] wd, input int flush_at, input int lo_from,
                         input int lo_len, input int io_cycles, output int lat,
                         output logic [31:0] rd);
    q_a.delete(); q_wr.delete(); q_do.delete();
    lat = 0;
    rd  = 32'd0;
    @(posedge clk_in); #1;
    if (use_lsb) begin
      lsb_en = 1'b1; lsb_addr = a; lsb_type = ty; lsb_write_data = wd;
    end else begin
      if_en = 1'b1; if_addr = a;
    end
    io_buffer_full = (io_cycles > 0);
    for (int cnt = 1; cnt <= 30; cnt++) begin
      @(posedge clk_in); #1;
      flush = (cnt == flush_at);
      if (cnt == flush_at) begin
        lsb_en = 1'b0; if_en = 1'b0;
      end
      rdy_in = !(cnt >= lo_from && cnt < lo_from + lo_len);
      io_buffer_full = (cnt <= io_cycles);
      #1;
      q_a.push_back(mem_a); q_wr.push_back(mem_wr); q_do.push_back(mem_dout);
      if (use_lsb ? lsb_rdy : if_rdy) begin
        lat = cnt;
        rd  = use_lsb ? lsb_read_data : if_data;
        break;
      end
    end
    lsb_en = 1'b0; if_en = 1'b0; flush = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
  endtask

  initial begin
    int          lat, kind, sz, n, diffs, k;
    bit          u, seen;
    logic [31:0] rd, a, wd;
    logic [3:0]  ty;

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; lsb_en = 1'b0; if_en = 1'b0;
    lsb_addr = 32'd0; lsb_type = 4'd0; lsb_write_data = 32'd0; if_addr = 32'd0;
    io_buffer_full = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h205] = 8'h80; ram[12'h206] = 8'h01; ram[12'h207] = 8'h80;
    for (int i = 0; i < 4096; i++) model[i] = ram[i];

    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_lsb_rdy", 32'(lsb_rdy), 32'd0);
    chk("rst_if_rdy", 32'(if_rdy), 32'd0);
    chk("rst_lsb_read_data", lsb_read_data, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    rst_in = 1'b0;

    // Word fetch from 0x100.
    run_req(1'b0, 32'h100, 4'b0010, 32'd0, 0, 0, 0, 0, lat, rd);
    chk("fetch_lat", 32'(lat), 32'd6);
    chk("fetch_data", rd, 32'h0000_0513);
    for (int j = 0; j < 4; j++) chk("fetch_addr_seq", q_a[j], 32'h100 + 32'(j));
    chk("fetch_addr_tail", q_a[4], 32'd0);
    @(posedge clk_in); #1;
    chk("fetch_idle_a", mem_a, 32'd0);
    chk("fetch_idle_rdy", 32'(if_rdy), 32'd0);

    // Byte/half loads with sign and zero extension.
    run_req(1'b1, 32'h205, 4'b0000, 32'd0, 0, 0, 0, 0, lat, rd);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_data", rd, 32'hFFFF_FF80);
    run_req(1'b1, 32'h205, 4'b0100, 32'd0, 0, 0, 0, 0, lat, rd);
    chk("lbu_data", rd, 32'h0000_0080);
    run_req(1'b1, 32'h206, 4'b0001, 32'd0, 0, 0, 0, 0, lat, rd);
    chk("lh_lat", 32'(lat), 32'd4);
    chk("lh_data", rd, 32'hFFFF_8001);

    // Word store; read data must not change.
    run_req(1'b1, 32'h300, 4'b1010, 32'hDEAD_BEEF, 0, 0, 0, 0, lat, rd);
    chk("sw_lat", 32'(lat), 32'd5);
    chk("sw_keeps_read_data", rd, 32'hFFFF_8001);
    check_writes("sw", 32'h300, 32'hDEAD_BEEF, 4);
    model_store(32'h300, 32'hDEAD_BEEF, 4);

    // Simultaneous requests: LSB first, fetch after one dead cycle.
    @(posedge clk_in); #1;
    lsb_en = 1'b1; lsb_addr = 32'h400; lsb_type = 4'b0010;
    if_en = 1'b1; if_addr = 32'h104;
    @(posedge clk_in); #1;
    chk("arb_lsb_first", mem_a, 32'h400);
    k = 1; seen = 1'b0;
    while (k < 20 && !seen) begin
      if (lsb_rdy) seen = 1'b1;
      else begin
        @(posedge clk_in); #1; k++;
      end
    end
    chk("arb_lsb_lat", 32'(k), 32'd6);
    chk("arb_lsb_data", lsb_read_data, model_load(32'h400, 4, 1'b0));
    lsb_en = 1'b0;
    @(posedge clk_in); #1;
    chk("arb_dead_a", mem_a, 32'd0);
    chk("arb_dead_rdy", 32'(if_rdy), 32'd0);
    @(posedge clk_in); #1;
    chk("arb_fetch_addr", mem_a, 32'h104);
    k = 1; seen = 1'b0;
    while (k < 20 && !seen) begin
      if (if_rdy) seen = 1'b1;
      else begin
        @(posedge clk_in); #1; k++;
      end
    end
    chk("arb_fetch_lat", 32'(k), 32'd6);
    chk("arb_fetch_data", if_data, model_load(32'h104, 4, 1'b0));
    if_en = 1'b0;

    // IO byte store stalled by a full buffer for three cycles.
    run_req(1'b1, 32'h0003_0000, 4'b1000, 32'h0000_00A5, 0, 0, 0, 3, lat, rd);
    chk("io_lat", 32'(lat), 32'd5);
    for (int j = 0; j < 3; j++) chk("io_stall_wr", 32'(q_wr[j]), 32'd0);
    chk("io_wr", 32'(q_wr[3]), 32'd1);
    chk("io_addr", q_a[3], 32'h0003_0000);
    chk("io_byte", 32'(io_d), 32'h0000_00A5);

    // Flush in the second cycle of a fetch aborts it.
    run_req(1'b0, 32'h108, 4'b0010, 32'd0, 2, 0, 0, 0, lat, rd);
    chk("flush_fetch_no_rdy", 32'(lat), 32'd0);
    chk("flush_fetch_a1", q_a[1], 32'h109);
    chk("flush_fetch_idle", q_a[2], 32'd0);

    // Flush during a store lets it finish.
    wd = $urandom;
    run_req(1'b1, 32'h500, 4'b1010, wd, 2, 0, 0, 0, lat, rd);
    chk("flush_sw_lat", 32'(lat), 32'd5);
    check_writes("flush_sw", 32'h500, wd, 4);
    model_store(32'h500, wd, 4);
    run_req(1'b1, 32'h500, 4'b0010, 32'd0, 0, 0, 0, 0, lat, rd);
    chk("flush_sw_readback", rd, wd);

    // Two frozen cycles mid-load.
    run_req(1'b1, 32'h600, 4'b0010, 32'd0, 0, 2, 2, 0, lat, rd);
    chk("freeze_lat", 32'(lat), 32'd8);
    chk("freeze_data", rd, model_load(32'h600, 4, 1'b0));

    // Random mix of fetches, loads and stores.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      a    = 32'($urandom_range(0, 4095));
      sz   = $urandom_range(0, 2);
      u    = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        run_req(1'b0, a, 4'b0010, 32'd0, 0, 0, 0, 0, lat, rd);
        chk("rnd_fetch_lat", 32'(lat), 32'd6);
        chk("rnd_fetch_data", rd, model_load(a, 4, 1'b0));
      end else if (kind == 1) begin
        ty = {1'b0, u, 2'(sz)};
        n  = nbytes(ty);
        run_req(1'b1, a, ty, 32'd0, 0, 0, 0, 0, lat, rd);
        chk("rnd_load_lat", 32'(lat), 32'(n + 2));
        chk("rnd_load_data", rd, model_load(a, n, !u));
      end else begin
        ty = {1'b1, 1'b0, 2'(sz)};
        n  = nbytes(ty);
        wd = $urandom;
        run_req(1'b1, a, ty, wd, 0, 0, 0, 0, lat, rd);
        chk("rnd_store_lat", 32'(lat), 32'(n + 1));
        check_writes("rnd_store", a, wd, n);
        model_store(a, wd, n);
      end
    end

    diffs = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== model[i]) diffs++;
    chk("ram_vs_model", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
# memory_controller

Single-port byte-serial memory controller that responds to the load/store buffer's `mc_*` request interface and to instruction-fetch word reads. It arbitrates between the two requesters and splits each access into little-endian byte transfers on the 8-bit RAM/IO bus. It sign- or zero-extends load data and returns one-cycle ready pulses.

## Interface
- `IO_BASE`, default `32'h0003_0000`: addresses with `addr[17:16]==2'b11` are IO and are subject to `io_buffer_full`.
- `clk_in`  in  1  clock
- `rst_in`  in  1  synchronous reset, active-high
- `rdy_in`  in  1  global enable; low freezes the block
- `flush`  in  1  misprediction flush
- `lsb_en`  in  1  LSB request valid, held until `lsb_rdy`
- `lsb_addr`  in  32  byte address
- `lsb_type`  in  4  [3]=store, [2]=unsigned load, [1:0]=size (00 byte, 01 half, 10 word)
- `lsb_write_data`  in  32  store data in low bytes
- `lsb_rdy`  out  1  one-cycle completion pulse
- `lsb_read_data`  out  32  extended load result, valid with `lsb_rdy`
- `if_en`  in  1  fetch request valid, held until `if_rdy`
- `if_addr`  in  32  fetch address (word read)
- `if_rdy`  out  1  one-cycle completion pulse
- `if_data`  out  32  instruction word, valid with `if_rdy`
- `mem_din`  in  8  RAM/IO read byte, valid one cycle after address
- `mem_dout`  out  8  write byte
- `mem_a`  out  32  byte address
- `mem_wr`  out  1  1 = write this cycle
- `io_buffer_full`  in  1  IO output buffer full

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: LSB request wins over fetch when both are pending. Latch the source, address, type, data and byte count n (1/2/4). Go to ACCESS with byte index i=0.
- ACCESS, read: drive `mem_a=addr+i` for i=0..n-1, `mem_wr=0`. Each cycle after an address, capture `mem_din` into byte i-1 of the result. The last capture happens in the cycle after address n-1, with `mem_a=0`.
- ACCESS, write: drive `mem_a=addr+i`, `mem_dout=data[8i+7:8i]`, `mem_wr=1` for i=0..n-1.
- IO stall: for a write with an IO address while `io_buffer_full=1`, drive `mem_wr=0` and keep i unchanged.
- Read completion: extend the result. Unsigned or word loads zero-extend from bit 8n-1; signed loads sign-extend. Register it into `lsb_read_data`/`if_data` and pulse the matching rdy in DONE.
- Write completion: pulse `lsb_rdy` in DONE; `lsb_read_data` is unchanged.
- DONE: the rdy pulse is high for exactly this cycle and both `en` inputs are ignored. Then go to IDLE. The requester drops or replaces `en` on the edge ending DONE.
- Idle bus: `mem_a=0`, `mem_wr=0`, `mem_dout=0`.
- Flush during a read (LSB load or fetch): abort, go to IDLE next cycle, no rdy pulse. Flush during a store: the store completes and `lsb_rdy` still pulses. Flush in IDLE or DONE: no effect except that a DONE read pulse is suppressed.
- Address arithmetic is 32-bit wrapping; no alignment check.

## Timing
- Reset: state IDLE, i=0, `lsb_rdy=0`, `if_rdy=0`, `lsb_read_data=0`, `if_data=0`, `mem_a=0`, `mem_dout=0`, `mem_wr=0`.
- Reset mid-access abandons it with no pulse.
- `rdy_in=0`: all registers hold and `mem_wr` is forced to 0. A write byte pending in that cycle is re-driven once `rdy_in` returns.
- Read latency, from the cycle `en` is sampled in IDLE to the rdy pulse: n+2 cycles (word 6, half 4, byte 3).
- Write latency: n+1 cycles plus IO stall cycles.
- Back-to-back: a new request is accepted in the IDLE cycle after DONE, i.e. one dead cycle between grants.
- Arbitration is evaluated only in IDLE. A fetch waiting behind an LSB request is served next if `lsb_en` is low in that IDLE cycle.

## Test plan
- Word fetch, `if_addr=0x100`, RAM bytes 13 05 00 00: `mem_a` shows 0x100..0x103 on consecutive cycles, then `if_rdy=1` with `if_data=0x00000513` exactly 6 cycles after accept, then one idle cycle.
- Signed byte load, addr 0x205 holding 0x80: `lsb_read_data=0xFFFFFF80`. The same load with type unsigned gives `0x00000080`. Signed half load of 0x8001 gives `0xFFFF8001`.
- Word store 0xDEADBEEF to 0x300: `mem_wr=1` for 4 cycles with (0x300,EF), (0x301,BE), (0x302,AD), (0x303,DE), then `lsb_rdy` pulse.
- `lsb_en` and `if_en` asserted in the same cycle: the LSB is served first. After its DONE, the fetch is accepted on the following IDLE cycle.
- Byte store to 0x30000 with `io_buffer_full=1` for 3 cycles: `mem_wr` stays 0 for those cycles, then one write cycle and the `lsb_rdy` pulse.
- Flush in the 2nd cycle of a word fetch: no `if_rdy`, bus idle next cycle. Flush during a store: the store finishes all bytes and `lsb_rdy` pulses. `rdy_in` low for 2 cycles mid-load: latency extends by exactly 2.
